cart_req_mux: RTL

Request router and buffer between the GBA cartridge bus front-end and the shared backing-memory port. It accepts single-cycle cart read/write strobes, queues them in a small FIFO, and translates cart addresses into memory byte addresses and byte enables for the ROM (CS1) and SRAM (CS2) spaces. It issues one memory access at a time and returns read data to the front-end with a one-cycle valid pulse. It also arbitrates a host (loader/debug) port onto the same memory, with cart traffic always taking priority.

---
 rtl/cart_req_mux.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cart_req_mux.sv
// cart_req_mux: queues cart bus strobes, translates ROM/SRAM addresses and
// arbitrates them with a host port onto a single memory port.
module cart_req_mux #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cart_rd,
    input  logic        cart_wr,
    input  logic [1:0]  cart_data_width,
    input  logic [25:0] cart_addr,
    input  logic [15:0] cart_wr_data,
    output logic [15:0] cart_rd_data,
    output logic        mux_rd_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [25:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [25:0] host_addr,
    input  logic [1:0]  host_be,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        busy,
    output logic        overflow,
    output logic        timeout_err,
    output logic        proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CART, HOST} state_t;
    typedef struct packed {
        logic        we;
        logic [25:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } req_t;

    state_t        state_q, state_d;
    req_t          fifo_q [FIFO_DEPTH];
    req_t          push_ent, head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push, full, accept, pop, expire, done, mismatch;
    logic [15:0]   rd_fmt;
    logic [15:0]   cart_rd_data_q, mem_wdata_q, host_rdata_q;
    logic [25:0]   mem_addr_q;
    logic [1:0]    mem_be_q;
    logic          mux_rd_valid_q, mem_req_q, mem_we_q, host_ack_q;
    logic          busy_q, overflow_q, timeout_err_q, proto_err_q;
    logic          unused_ok;

    assign unused_ok = host_addr[0];

    // Entries are stored already translated so the CART state only replays them.
    always_comb begin
        push_ent.we    = cart_wr;
        push_ent.addr  = cart_addr[25] ? {1'b1, 9'b0, cart_addr[15:1], 1'b0} : {1'b0, cart_addr[24:1], 1'b0};
        push_ent.be    = cart_addr[25] ? (cart_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        push_ent.wdata = cart_addr[25] ? {2{cart_wr_data[7:0]}} : cart_wr_data;
    end

    always_comb begin
        push     = cart_rd | cart_wr;
        full     = cnt_q == (AW+1)'(FIFO_DEPTH);
        expire   = state_q != IDLE && !mem_ack && tmo_q == TW'(TIMEOUT - 1);
        done     = state_q != IDLE && (mem_ack || expire);
        pop      = state_q == CART && done;
        accept   = push && (!full || pop);
        cnt_d    = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
        head     = cnt_q != '0 ? fifo_q[rd_ptr_q] : push_ent;
        mismatch = cart_data_width != (cart_addr[25] ? 2'b01 : 2'b10);
        rd_fmt   = !mem_ack ? 16'hFFFF : !mem_addr_q[25] ? mem_rdata :
                   {8'h00, mem_be_q[1] ? mem_rdata[15:8] : mem_rdata[7:0]};
        state_d  = state_q == IDLE ? ((cnt_q != '0 || accept) ? CART : (host_req ? HOST : IDLE)) :
                   (done ? IDLE : state_q);
        tmo_d    = (state_q != IDLE && !done) ? tmo_q + TW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_q[wr_ptr_q] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            cart_rd_data_q <= '0;
            mux_rd_valid_q <= 1'b0;
            host_ack_q     <= 1'b0;
            host_rdata_q   <= '0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            mem_req_q <= state_d != IDLE;
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (state_q == IDLE && state_d == CART) begin
                mem_we_q    <= head.we;
                mem_addr_q  <= head.addr;
                mem_be_q    <= head.be;
                mem_wdata_q <= head.wdata;
            end else if (state_q == IDLE && state_d == HOST) begin
                mem_we_q    <= host_we;
                mem_addr_q  <= {host_addr[25:1], 1'b0};
                mem_be_q    <= host_be;
                mem_wdata_q <= host_wdata;
            end
            mux_rd_valid_q <= pop && !mem_we_q;
            if (pop && !mem_we_q) cart_rd_data_q <= rd_fmt;
            host_ack_q <= state_q == HOST && done;
            if (state_q == HOST && done && (!mem_ack || !mem_we_q)) host_rdata_q <= mem_ack ? mem_rdata : 16'hFFFF;
            busy_q        <= state_d != IDLE || cnt_d != '0;
            overflow_q    <= overflow_q | (push && full && !pop);
            timeout_err_q <= timeout_err_q | expire;
            proto_err_q   <= proto_err_q | (cart_rd && cart_wr) | (push && mismatch);
        end
    end

    assign cart_rd_data = cart_rd_data_q;
    assign mux_rd_valid = mux_rd_valid_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign timeout_err  = timeout_err_q;
    assign proto_err    = proto_err_q;
endmodule
